// File: rtl/timer_bank.sv
// Bank of NUM_CH programmable periodic/one-shot interval timers with sticky flags and a shared irq.
// Optional shared prescaler enabled by defining TIMER_BANK_PRESCALE_EN.
module timer_bank #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en_i,
    input  logic [NUM_CH-1:0]       oneshot_i,
    input  logic [NUM_CH-1:0]       start_i,
    input  logic [NUM_CH*WIDTH-1:0] limit_i,
    input  logic [NUM_CH-1:0]       flag_clr_i,
`ifdef TIMER_BANK_PRESCALE_EN
    input  logic [PRESCALE_W-1:0]   prescale_i,
`endif
    output logic [NUM_CH*WIDTH-1:0] count_o,
    output logic [NUM_CH-1:0]       busy_o,
    output logic [NUM_CH-1:0]       done_o,
    output logic [NUM_CH-1:0]       flag_o,
    output logic                    irq_o
);

    typedef enum logic {StIdle, StRun} state_e;

    if (NUM_CH < 1 || NUM_CH > 16 || WIDTH < 1 || PRESCALE_W < 1) begin : g_bad_param
        $error("timer_bank: parameter out of range");
    end

    logic tick;

`ifdef TIMER_BANK_PRESCALE_EN
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

    // >= so that lowering prescale below the running count wraps at once
    assign tick   = (pcnt_q >= prescale_i);
    assign pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [WIDTH-1:0] count_q, count_d;
        logic [WIDTH-1:0] lim, lim_m1;
        logic             done_q, done_d;
        logic             flag_q, flag_d;

        assign lim    = limit_i[i*WIDTH +: WIDTH];
        // A zero limit behaves as one, so L-1 never underflows
        assign lim_m1 = (lim == '0) ? '0 : lim - WIDTH'(1);

        always_comb begin
            state_d = state_q;
            count_d = count_q;
            done_d  = 1'b0;
            if (!en_i[i]) begin
                state_d = StIdle;
                count_d = '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (!oneshot_i[i] || start_i[i]) begin
                            state_d = StRun;
                            count_d = '0;
                        end
                    end
                    StRun: begin
                        if (tick) begin
                            if (count_q >= lim_m1) begin
                                count_d = '0;
                                done_d  = 1'b1;
                                if (oneshot_i[i]) begin
                                    state_d = StIdle;
                                end
                            end else begin
                                count_d = count_q + WIDTH'(1);
                            end
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
            flag_d = done_d | (flag_q & ~flag_clr_i[i]);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= StIdle;
                count_q <= '0;
                done_q  <= 1'b0;
                flag_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                done_q  <= done_d;
                flag_q  <= flag_d;
            end
        end

        assign count_o[i*WIDTH +: WIDTH] = count_q;
        assign busy_o[i]                 = (state_q == StRun);
        assign done_o[i]                 = done_q;
        assign flag_o[i]                 = flag_q;
    end

    assign irq_o = |flag_o;

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: per-cycle expectations are queued with the stimulus
// and popped one clock edge later.
module tb_timer_bank;

    localparam int unsigned NC = 4;
    localparam int unsigned W  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NC-1:0]   en = '0, oneshot = '0, start = '0, flag_clr = '0;
    logic [NC*W-1:0] limit = '0;
    logic [NC*W-1:0] count;
    logic [NC-1:0]   busy, done, flag;
    logic            irq;
`ifdef TIMER_BANK_PRESCALE_EN
    logic [7:0]      prescale = '0;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        int          ch;
        logic [31:0] cnt;
        logic        busy;
        logic        done;
        logic        flag;
    } exp_t;

    exp_t exp_q[$];

    timer_bank #(.NUM_CH(NC), .WIDTH(W), .PRESCALE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en),
        .oneshot_i (oneshot),
        .start_i   (start),
        .limit_i   (limit),
        .flag_clr_i(flag_clr),
`ifdef TIMER_BANK_PRESCALE_EN
        .prescale_i(prescale),
`endif
        .count_o   (count),
        .busy_o    (busy),
        .done_o    (done),
        .flag_o    (flag),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic expect_ch(input string tag, input int ch, input logic [31:0] c,
                             input logic b, input logic d, input logic f);
        exp_t e;
        e.tag = tag; e.ch = ch; e.cnt = c; e.busy = b; e.done = d; e.flag = f;
        exp_q.push_back(e);
    endtask

    task automatic expect_irq(input string tag, input logic v);
        expect_ch(tag, -1, '0, 1'b0, 1'b0, v);
    endtask

    // Advance one edge, then compare everything queued for that edge
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.ch < 0) begin
                check_eq({e.tag, ".irq"}, 64'(irq), 64'(e.flag));
            end else begin
                check_eq({e.tag, ".cnt"},  64'(count[e.ch*W +: W]), 64'(e.cnt));
                check_eq({e.tag, ".busy"}, 64'(busy[e.ch]), 64'(e.busy));
                check_eq({e.tag, ".done"}, 64'(done[e.ch]), 64'(e.done));
                check_eq({e.tag, ".flag"}, 64'(flag[e.ch]), 64'(e.flag));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_eq("rst.count", 64'(count != '0), 64'd0);
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.done", 64'(done), 64'd0);
        check_eq("rst.flag", 64'(flag), 64'd0);
        check_eq("rst.irq", 64'(irq), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Periodic, limit 4: done at edges 5, 9, 13
        limit[0*W +: W] = 4;
        en[0] = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            expect_ch($sformatf("per.k%0d", k), 0, 32'((k - 1) % 4), 1'b1,
                      (k >= 5) && ((k - 1) % 4 == 0), k >= 5);
            step();
        end
        en[0] = 1'b0;
        expect_ch("per.off", 0, 0, 1'b0, 1'b0, 1'b1);
        expect_irq("per.off", 1'b1);
        step();
        flag_clr[0] = 1'b1;
        expect_ch("per.clr", 0, 0, 1'b0, 1'b0, 1'b0);
        expect_irq("per.clr", 1'b0);
        step();
        flag_clr[0] = 1'b0;

        // One-shot, limit 3, with an ignored retrigger and a relaunch in the done cycle
        limit[1*W +: W] = 3;
        oneshot[1] = 1'b1; en[1] = 1'b1; start[1] = 1'b1;
        expect_ch("os.e0", 1, 0, 1'b1, 1'b0, 1'b0); step();
        expect_ch("os.e1", 1, 1, 1'b1, 1'b0, 1'b0); step();
        start[1] = 1'b0;
        expect_ch("os.e2", 1, 2, 1'b1, 1'b0, 1'b0); step();
        expect_ch("os.e3", 1, 0, 1'b0, 1'b1, 1'b1); step();
        start[1] = 1'b1;
        expect_ch("os.e4", 1, 0, 1'b1, 1'b0, 1'b1); step();
        start[1] = 1'b0;
        expect_ch("os.e5", 1, 1, 1'b1, 1'b0, 1'b1); step();
        expect_ch("os.e6", 1, 2, 1'b1, 1'b0, 1'b1); step();
        expect_ch("os.e7", 1, 0, 1'b0, 1'b1, 1'b1); step();
        expect_ch("os.e8", 1, 0, 1'b0, 1'b0, 1'b1); step();
        en[1] = 1'b0; flag_clr[1] = 1'b1;
        expect_ch("os.clr", 1, 0, 1'b0, 1'b0, 1'b0); step();
        flag_clr[1] = 1'b0; oneshot[1] = 1'b0;

        // limit 0 and 1 wrap every tick; clear+set on the same edge keeps the flag
        limit[2*W +: W] = 0;
        limit[3*W +: W] = 1;
        en[3:2] = 2'b11;
        for (int c = 2; c <= 3; c++) expect_ch($sformatf("l01.e1.c%0d", c), c, 0, 1'b1, 1'b0, 1'b0);
        step();
        for (int c = 2; c <= 3; c++) expect_ch($sformatf("l01.e2.c%0d", c), c, 0, 1'b1, 1'b1, 1'b1);
        step();
        flag_clr[2] = 1'b1;
        for (int c = 2; c <= 3; c++) expect_ch($sformatf("l01.e3.c%0d", c), c, 0, 1'b1, 1'b1, 1'b1);
        step();
        flag_clr[2] = 1'b0;
        en[3:2] = 2'b00;
        for (int c = 2; c <= 3; c++) expect_ch($sformatf("l01.off.c%0d", c), c, 0, 1'b0, 1'b0, 1'b1);
        step();
        flag_clr = 4'b0100;
        expect_ch("l01.clr2", 2, 0, 1'b0, 1'b0, 1'b0);
        expect_irq("l01.clr2", 1'b1);
        step();
        flag_clr = 4'b1000;
        expect_ch("l01.clr3", 3, 0, 1'b0, 1'b0, 1'b0);
        expect_irq("l01.clr3", 1'b0);
        step();
        flag_clr = '0;

        // Limit drop from 100 to 10 at count 50 wraps on the next tick
        limit[0*W +: W] = 100;
        en[0] = 1'b1;
        for (int k = 0; k < 50; k++) step();
        expect_ch("drop.c50", 0, 50, 1'b1, 1'b0, 1'b0); step();
        limit[0*W +: W] = 10;
        expect_ch("drop.wrap", 0, 0, 1'b1, 1'b1, 1'b1); step();
        limit[0*W +: W] = 100;
        for (int k = 0; k < 49; k++) step();
        expect_ch("rst.c50", 0, 50, 1'b1, 1'b0, 1'b1); step();

        // Asynchronous reset mid-period
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst.count", 64'(count != '0), 64'd0);
        check_eq("arst.busy", 64'(busy), 64'd0);
        check_eq("arst.done", 64'(done), 64'd0);
        check_eq("arst.flag", 64'(flag), 64'd0);
        check_eq("arst.irq", 64'(irq), 64'd0);
        #2;
        rst = 1'b0;
        expect_ch("arst.resume", 0, 0, 1'b1, 1'b0, 1'b0); step();
        en = '0;
        step();

`ifdef TIMER_BANK_PRESCALE_EN
        begin
            int t0, gap0, gap1;
            prescale = 8'd2;
            limit[0*W +: W] = 2;
            limit[1*W +: W] = 3;
            en[1:0] = 2'b11;
            for (int c = 0; c <= 1; c++) begin
                t0 = -1;
                gap0 = 0;
                gap1 = 0;
                for (int k = 0; k < 200 && gap1 == 0; k++) begin
                    step();
                    if (done[c]) begin
                        if (t0 < 0) t0 = k;
                        else if (gap0 == 0) gap0 = k - t0;
                        else gap1 = k - t0 - gap0;
                    end
                end
                check_eq($sformatf("pre.gap0.c%0d", c), 64'(gap0), 64'(c == 0 ? 6 : 9));
                check_eq($sformatf("pre.gap1.c%0d", c), 64'(gap1), 64'(c == 0 ? 6 : 9));
            end
            en = '0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
# timer_bank

Bank of `NUM_CH` independent programmable interval timers sharing one clock and one optional prescaler. It is the general-purpose timing source for the control loop: the PID sample tick, ultrasonic trigger/echo timeouts and motor-update pacing. Each channel runs either free-running periodic or one-shot. Each raises a one-cycle `done` pulse and a sticky interrupt flag, and the flags are OR-reduced into a single `irq`.

## Interface
- `NUM_CH`, default 4: number of timer channels, range 1 to 16.
- `WIDTH`, default 32: counter and limit width in bits.
- `PRESCALE_W`, default 8: prescaler width. Used only when `TIMER_BANK_PRESCALE_EN` is defined.

- `clk`: input, 1 bit. Clock.
- `rst`: input, 1 bit. Reset, asynchronous, active-high.
- `en`: input, `NUM_CH` bits. Per-channel enable. Low holds the channel cleared.
- `oneshot`: input, `NUM_CH` bits. Mode select: 1 means one-shot, 0 means periodic.
- `start`: input, `NUM_CH` bits. One-shot launch pulse. Ignored in periodic mode.
- `limit`: input, `NUM_CH*WIDTH` bits. Packed period in ticks; channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `flag_clr`: input, `NUM_CH` bits. Clears the sticky flags.
- `prescale`: input, `PRESCALE_W` bits. Tick divider minus one. This port exists only when `TIMER_BANK_PRESCALE_EN` is defined.
- `count`: output, `NUM_CH*WIDTH` bits. Packed current counts.
- `busy`: output, `NUM_CH` bits. Channel is counting.
- `done`: output, `NUM_CH` bits. One-cycle pulse on period completion.
- `flag`: output, `NUM_CH` bits. Sticky completion flags.
- `irq`: output, 1 bit. OR of all `flag` bits. Combinational.

## Operation
- Reset values: all `count`, `done`, `flag` and `busy` bits are 0, and all channel states are IDLE. The prescaler counter is 0. `irq` is 0.
- The effective limit is L = max(`limit[i]`, 1). A limit of 0 therefore behaves as 1.
- "Tick" is a shared enable. Without the macro it is constantly 1.
- Each channel has a two-state FSM, IDLE and RUN. `busy` is high exactly when the channel is in RUN.
- `en[i]` = 0, in any state: next state is IDLE, `count` goes to 0, `done` goes to 0. This takes priority over everything else in the channel.
- Periodic mode (`oneshot[i]` = 0, `en[i]` = 1):
  - From IDLE the channel moves to RUN on the next clock.
  - In RUN, on each tick: if `count` >= L-1, then `count` goes to 0 and `done` goes to 1; otherwise `count` increments.
  - The comparison is >= so that lowering `limit` mid-period wraps immediately instead of running to 2^WIDTH.
- One-shot mode (`oneshot[i]` = 1, `en[i]` = 1):
  - `start` in IDLE moves the channel to RUN with `count` at 0.
  - In RUN, ticks count exactly as in periodic mode. At the wrap, `done` goes to 1 and the state returns to IDLE.
  - `start` while in RUN is ignored; there is no retrigger.
- Changing `oneshot` while in RUN takes effect at the next wrap decision.
- `done` is cleared every cycle in which no wrap occurs.
- `flag[i]` is set on the same edge that sets `done[i]` and is cleared by `flag_clr[i]`. If both happen on the same edge, set wins.
- Arithmetic is unsigned at `WIDTH` bits. L-1 is computed at `WIDTH` bits, and L >= 1 guarantees it cannot underflow.

## Timing
- Periodic, tick every cycle, limit = N: `done` pulses every N cycles.
  - The first pulse comes N+1 cycles after `en` rises, because of the IDLE-to-RUN cycle.
  - `done` is high in the same cycle that `count` reads 0.
- One-shot: `start` is sampled at edge 0. `done` is high after edge N, with `busy` low in that same cycle. A new `start` is accepted in that cycle.
- `irq` follows `flag` combinationally, with no added latency.
- Asserting `rst` mid-period returns every output to its reset value immediately (asynchronously). After deassertion, channels need `en` (periodic) or `start` (one-shot) to resume.

## Configuration
- `TIMER_BANK_PRESCALE_EN` defined:
  - The `prescale` port exists, and a shared counter `pcnt` runs from 0 to `prescale`.
  - Tick = (`pcnt` == `prescale`), so ticks occur every `prescale`+1 cycles. `prescale` = 0 gives a tick every cycle.
  - `pcnt` is free-running, independent of `en`. It wraps to 0 on the tick edge. If `prescale` drops below `pcnt`, the comparison is >= and it wraps immediately.
- `TIMER_BANK_PRESCALE_EN` not defined: there is no `prescale` port and no prescaler logic, and tick = 1.

## Test plan
- Periodic, limit=4, `en` held high from cycle 0, no prescale: `done` high at cycles 5, 9, 13. `count` sequence 0,0,1,2,3,0,1,... and `flag` set from cycle 5.
- One-shot, limit=3, `start` pulse: `busy` high for 3 cycles, a single `done` pulse, then IDLE. A second `start` during RUN produces no extra pulse. A `start` in the `done` cycle launches a new shot.
- limit=0 and limit=1: `done` high every cycle in RUN, with `count` stuck at 0.
- `flag_clr` and a wrap on the same edge: `flag` stays 1. `flag_clr` alone: `flag` goes to 0 and `irq` goes to 0 once all channels are clear.
- Mid-period `limit` drop from 100 to 10 while `count`=50: wrap with `done` on the next tick. Separately, `rst` pulse at `count`=50: all outputs 0 immediately.
- With `TIMER_BANK_PRESCALE_EN`, prescale=2, limit=2: `done` every 6 cycles. Other channels with different limits remain independent.
